// File: rtl/hist_job_sched_pkg.sv
// Shared types and constants for the histogram job scheduler: FSM states,
// status codes, the queued job record and the set of legal grid divisions.
package hist_job_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_LBP_RUN   = 3'd2,
    ST_HCU_RUN   = 3'd3,
    ST_MATCH_RUN = 3'd4,
    ST_REPORT    = 3'd5
  } state_t;

  localparam logic [1:0] STAT_OK       = 2'b00;
  localparam logic [1:0] STAT_BAD_GRID = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT  = 2'b10;
  localparam logic [1:0] STAT_RSVD     = 2'b11;

  // Bit n set means a grid division of n is legal: {1, 2, 4, 8}.
  localparam logic [15:0] LEGAL_GRID_MASK = 16'h0116;

  typedef struct packed {
    logic [2:0] id;
    logic       mode;
    logic [3:0] grid_x;
    logic [3:0] grid_y;
  } job_t;

  function automatic logic grid_legal(input logic [3:0] g);
    return LEGAL_GRID_MASK[g];
  endfunction

endpackage

// File: rtl/hist_job_sched_if.sv
// Command, engine-control and status signals of the job scheduler.
// master = job source / engines side, slave = scheduler side.
interface hist_job_sched_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_mode;
  logic [3:0] cmd_gridX;
  logic [3:0] cmd_gridY;
  logic       lbp_start;
  logic       lbp_done;
  logic       hcu_enable;
  logic       hcu_mode;
  logic [3:0] hcu_gridX;
  logic [3:0] hcu_gridY;
  logic       hcu_done;
  logic       match_start;
  logic       match_done;
  logic       stat_valid;
  logic [2:0] stat_id;
  logic [1:0] stat_code;
  logic       busy;

  modport master (
    output cmd_valid, cmd_mode, cmd_gridX, cmd_gridY, lbp_done, hcu_done, match_done,
    input  cmd_ready, lbp_start, hcu_enable, hcu_mode, hcu_gridX, hcu_gridY,
           match_start, stat_valid, stat_id, stat_code, busy
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_gridX, cmd_gridY, lbp_done, hcu_done, match_done,
    output cmd_ready, lbp_start, hcu_enable, hcu_mode, hcu_gridX, hcu_gridY,
           match_start, stat_valid, stat_id, stat_code, busy
  );
endinterface

// File: rtl/hist_job_sched_job_fifo.sv
// Synchronous show-ahead FIFO for queued jobs; full/empty come straight from
// the registered occupancy so the caller never pushes and pops a full FIFO.
module job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
endmodule

// File: rtl/hist_job_sched.sv
// Job scheduler: queues train/predict commands and sequences each one through
// the LBP generator, histogram unit and (predict only) matcher with a watchdog.
module hist_job_sched
  import hist_job_sched_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input logic             clk,
  input logic             rst,
  hist_job_sched_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state_r, state_nxt_s;
  job_t          job_r, head_s, cmd_job_s;
  logic [2:0]    id_r;
  logic [15:0]   wd_r;
  logic [1:0]    code_r, code_nxt_s;
  logic          push_s, pop_s, full_s, empty_s;
  logic [CW-1:0] count_s, count_nxt_s;
  logic          timeout_s, first_s, in_run_s;
  logic          lbp_start_r, match_start_r, hcu_enable_r, stat_valid_r, busy_r;

  assign cmd_job_s   = {id_r, bus.cmd_mode, bus.cmd_gridX, bus.cmd_gridY};
  assign push_s      = bus.cmd_valid & ~full_s;
  assign count_nxt_s = count_s + CW'(push_s) - CW'(pop_s);
  assign timeout_s   = (wd_r == TIMEOUT_CYC - 16'd1);
  // First cycle of a RUN state: a done here coincides with the start pulse.
  assign first_s     = (wd_r == 16'd0);
  assign in_run_s    = state_r inside {ST_LBP_RUN, ST_HCU_RUN, ST_MATCH_RUN};

  job_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(job_t))) u_job_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (cmd_job_s),
    .pop   (pop_s),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Next-state, completion code and FIFO pop.
  always_comb begin
    state_nxt_s = state_r;
    code_nxt_s  = code_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          state_nxt_s = ST_CHECK;
          pop_s       = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (grid_legal(job_r.grid_x) && grid_legal(job_r.grid_y)) begin
          state_nxt_s = ST_LBP_RUN;
        end else begin
          state_nxt_s = ST_REPORT;
          code_nxt_s  = STAT_BAD_GRID;
        end
      end
      ST_LBP_RUN: begin
        if (bus.lbp_done && !first_s) begin
          state_nxt_s = ST_HCU_RUN;
        end else if (timeout_s) begin
          state_nxt_s = ST_REPORT;
          code_nxt_s  = STAT_TIMEOUT;
        end else begin
          state_nxt_s = ST_LBP_RUN;
        end
      end
      ST_HCU_RUN: begin
        if (bus.hcu_done) begin
          if (job_r.mode) begin
            state_nxt_s = ST_MATCH_RUN;
          end else begin
            state_nxt_s = ST_REPORT;
            code_nxt_s  = STAT_OK;
          end
        end else if (timeout_s) begin
          state_nxt_s = ST_REPORT;
          code_nxt_s  = STAT_TIMEOUT;
        end else begin
          state_nxt_s = ST_HCU_RUN;
        end
      end
      ST_MATCH_RUN: begin
        if (bus.match_done && !first_s) begin
          state_nxt_s = ST_REPORT;
          code_nxt_s  = STAT_OK;
        end else if (timeout_s) begin
          state_nxt_s = ST_REPORT;
          code_nxt_s  = STAT_TIMEOUT;
        end else begin
          state_nxt_s = ST_MATCH_RUN;
        end
      end
      ST_REPORT: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State, job registers, id counter and per-stage watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      code_r  <= STAT_OK;
      job_r   <= {$bits(job_t){1'b0}};
      id_r    <= 3'd0;
      wd_r    <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      code_r  <= code_nxt_s;
      if (pop_s)  job_r <= head_s;
      if (push_s) id_r  <= id_r + 3'd1;
      if ((state_nxt_s != state_r) || !in_run_s) wd_r <= 16'd0;
      else                                       wd_r <= wd_r + 16'd1;
    end
  end

  // Registered control and status outputs, derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lbp_start_r   <= 1'b0;
      match_start_r <= 1'b0;
      hcu_enable_r  <= 1'b0;
      stat_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      lbp_start_r   <= (state_r == ST_CHECK) && (state_nxt_s == ST_LBP_RUN);
      match_start_r <= (state_r == ST_HCU_RUN) && (state_nxt_s == ST_MATCH_RUN);
      hcu_enable_r  <= (state_nxt_s == ST_HCU_RUN);
      stat_valid_r  <= (state_nxt_s == ST_REPORT);
      busy_r        <= (state_nxt_s != ST_IDLE) || (count_nxt_s != {CW{1'b0}});
    end
  end

  assign bus.cmd_ready   = ~full_s;
  assign bus.lbp_start   = lbp_start_r;
  assign bus.match_start = match_start_r;
  assign bus.hcu_enable  = hcu_enable_r;
  assign bus.hcu_mode    = job_r.mode;
  assign bus.hcu_gridX   = job_r.grid_x;
  assign bus.hcu_gridY   = job_r.grid_y;
  assign bus.stat_valid  = stat_valid_r;
  assign bus.stat_id     = job_r.id;
  assign bus.stat_code   = code_r;
  assign bus.busy        = busy_r;
endmodule

// File: tb/tb_hist_job_sched.sv
// Directed bench for hist_job_sched: train, predict, bad grid, queue fill,
// watchdog timeout, id wrap and mid-job reset, with hand-computed expectations.
module tb_hist_job_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;

  hist_job_sched_if bus();

  hist_job_sched #(.FIFO_DEPTH(4), .TIMEOUT_CYC(16'd20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stat_cnt = 0;
  int lbp_cnt = 0;
  int match_cnt = 0;
  logic [2:0] stat_ids[$];
  logic [1:0] stat_codes[$];
  logic [3:0] gx_tab[5] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd2};
  logic [3:0] gy_tab[5] = '{4'd1, 4'd8, 4'd4, 4'd1, 4'd2};

  // Record completion reports and start pulses away from the active edge.
  always @(negedge clk) begin
    if (bus.stat_valid) begin
      stat_cnt++;
      stat_ids.push_back(bus.stat_id);
      stat_codes.push_back(bus.stat_code);
    end
    if (bus.lbp_start)   lbp_cnt++;
    if (bus.match_start) match_cnt++;
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.lbp_start;
      1:       return bus.hcu_enable;
      2:       return bus.match_start;
      3:       return bus.stat_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_high(input string tag, input int which, input int max_cyc);
    int n;
    n = 0;
    while (!sig(which) && n < max_cyc) begin
      tick();
      n++;
    end
    check_val(tag, 16'(sig(which)), 16'd1);
  endtask

  task automatic push_cmd(input logic mode, input logic [3:0] gx, input logic [3:0] gy);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = mode;
    bus.cmd_gridX = gx;
    bus.cmd_gridY = gy;
    check_val("push_ready", 16'(bus.cmd_ready), 16'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic serve_job(input logic predict, input logic wait_start, input logic [2:0] exp_id);
    if (wait_start) wait_high("job_lbp_start", 0, 8);
    tick();
    bus.lbp_done = 1'b1;
    tick();
    bus.lbp_done = 1'b0;
    check_val("job_hcu_en", 16'(bus.hcu_enable), 16'd1);
    tick();
    bus.hcu_done = 1'b1;
    tick();
    bus.hcu_done = 1'b0;
    if (predict) begin
      check_val("job_match_start", 16'(bus.match_start), 16'd1);
      tick();
      bus.match_done = 1'b1;
      tick();
      bus.match_done = 1'b0;
    end
    check_val("job_stat_valid", 16'(bus.stat_valid), 16'd1);
    check_val("job_stat_id", 16'(bus.stat_id), 16'(exp_id));
    check_val("job_stat_code", 16'(bus.stat_code), 16'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n, s0, l0;
    bus.cmd_valid = 1'b0; bus.cmd_mode = 1'b0; bus.cmd_gridX = 4'd0; bus.cmd_gridY = 4'd0;
    bus.lbp_done = 1'b0; bus.hcu_done = 1'b0; bus.match_done = 1'b0;
    tick(); tick();
    check_val("rst_ready", 16'(bus.cmd_ready), 16'd1);
    check_val("rst_busy", 16'(bus.busy), 16'd0);
    check_val("rst_hcu_en", 16'(bus.hcu_enable), 16'd0);
    check_val("rst_stat_valid", 16'(bus.stat_valid), 16'd0);
    check_val("rst_lbp_start", 16'(bus.lbp_start), 16'd0);
    rst = 1'b0;

    // Train 4x4, lbp_done ten cycles after the start pulse.
    push_cmd(1'b0, 4'd4, 4'd4);
    check_val("t1_busy", 16'(bus.busy), 16'd1);
    tick();
    check_val("t1_grid_x", 16'(bus.hcu_gridX), 16'd4);
    check_val("t1_grid_y", 16'(bus.hcu_gridY), 16'd4);
    check_val("t1_mode", 16'(bus.hcu_mode), 16'd0);
    tick();
    check_val("t1_lbp_start", 16'(bus.lbp_start), 16'd1);
    tick();
    check_val("t1_lbp_pulse_end", 16'(bus.lbp_start), 16'd0);
    repeat (8) tick();
    check_val("t1_hcu_en_wait", 16'(bus.hcu_enable), 16'd0);
    bus.lbp_done = 1'b1;
    tick();
    bus.lbp_done = 1'b0;
    check_val("t1_hcu_en", 16'(bus.hcu_enable), 16'd1);
    repeat (3) tick();
    check_val("t1_hcu_en_hold", 16'(bus.hcu_enable), 16'd1);
    bus.hcu_done = 1'b1;
    tick();
    bus.hcu_done = 1'b0;
    check_val("t1_stat_valid", 16'(bus.stat_valid), 16'd1);
    check_val("t1_stat_id", 16'(bus.stat_id), 16'd0);
    check_val("t1_stat_code", 16'(bus.stat_code), 16'd0);
    check_val("t1_hcu_en_drop", 16'(bus.hcu_enable), 16'd0);
    check_val("t1_no_match", 16'(match_cnt), 16'd0);
    tick();
    check_val("t1_stat_pulse_end", 16'(bus.stat_valid), 16'd0);
    check_val("t1_idle_busy", 16'(bus.busy), 16'd0);

    // Predict 8x8; dones arriving with their start pulse or out of state are ignored.
    push_cmd(1'b1, 4'd8, 4'd8);
    tick();
    tick();
    check_val("t2_lbp_start", 16'(bus.lbp_start), 16'd1);
    bus.lbp_done = 1'b1;
    tick();
    check_val("t2_lbp_done_same_cycle", 16'(bus.hcu_enable), 16'd0);
    tick();
    bus.lbp_done = 1'b0;
    check_val("t2_hcu_en", 16'(bus.hcu_enable), 16'd1);
    check_val("t2_hcu_mode", 16'(bus.hcu_mode), 16'd1);
    bus.match_done = 1'b1;
    tick();
    check_val("t2_match_done_early", 16'(bus.stat_valid), 16'd0);
    bus.hcu_done = 1'b1;
    tick();
    bus.hcu_done = 1'b0;
    check_val("t2_match_start", 16'(bus.match_start), 16'd1);
    check_val("t2_hcu_en_drop", 16'(bus.hcu_enable), 16'd0);
    tick();
    check_val("t2_match_done_same_cycle", 16'(bus.stat_valid), 16'd0);
    check_val("t2_match_pulse_end", 16'(bus.match_start), 16'd0);
    tick();
    bus.match_done = 1'b0;
    check_val("t2_stat_valid", 16'(bus.stat_valid), 16'd1);
    check_val("t2_stat_id", 16'(bus.stat_id), 16'd1);
    check_val("t2_stat_code", 16'(bus.stat_code), 16'd0);
    tick();

    // Illegal grids report code 01 two cycles after the pop, with no start pulse.
    push_cmd(1'b0, 4'd3, 4'd4);
    l0 = lbp_cnt;
    tick();
    check_val("t3_no_early_stat", 16'(bus.stat_valid), 16'd0);
    tick();
    check_val("t3_stat_valid", 16'(bus.stat_valid), 16'd1);
    check_val("t3_stat_code", 16'(bus.stat_code), 16'd1);
    check_val("t3_stat_id", 16'(bus.stat_id), 16'd2);
    tick();
    push_cmd(1'b1, 4'd8, 4'd0);
    tick();
    tick();
    check_val("t3b_stat_code", 16'(bus.stat_code), 16'd1);
    check_val("t3b_stat_valid", 16'(bus.stat_valid), 16'd1);
    tick();
    check_val("t3_no_lbp", 16'(lbp_cnt - l0), 16'd0);

    // Fill the queue behind a running job, then complete all five in order.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stat_ids.delete();
    stat_codes.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.cmd_gridX = gx_tab[k];
      bus.cmd_gridY = gy_tab[k];
      check_val($sformatf("t4_ready_%0d", k), 16'(bus.cmd_ready), 16'd1);
      tick();
    end
    bus.cmd_valid = 1'b0;
    check_val("t4_ready_full", 16'(bus.cmd_ready), 16'd0);
    check_val("t4_busy", 16'(bus.busy), 16'd1);
    for (int k = 0; k < 5; k++) begin
      serve_job(1'b0, k != 0, 3'(k));
    end
    check_val("t4_stat_count", 16'(stat_ids.size()), 16'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < stat_ids.size()) begin
        check_val($sformatf("t4_order_%0d", k), 16'(stat_ids[k]), 16'(k));
      end
    end

    // Watchdog on a withheld hcu_done while a second job waits.
    push_cmd(1'b0, 4'd2, 4'd2);
    wait_high("t5_lbp_start", 0, 8);
    tick();
    bus.lbp_done = 1'b1;
    tick();
    bus.lbp_done = 1'b0;
    n = bus.hcu_enable ? 1 : 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 1'b1;
    bus.cmd_gridX = 4'd1;
    bus.cmd_gridY = 4'd1;
    tick();
    bus.cmd_valid = 1'b0;
    if (bus.hcu_enable) n++;
    while (bus.hcu_enable && n < 40) begin
      tick();
      if (bus.hcu_enable) n++;
    end
    check_val("t5_hcu_cycles", 16'(n), 16'd20);
    check_val("t5_stat_valid", 16'(bus.stat_valid), 16'd1);
    check_val("t5_stat_code", 16'(bus.stat_code), 16'd2);
    check_val("t5_stat_id", 16'(bus.stat_id), 16'd5);
    tick();
    serve_job(1'b1, 1'b1, 3'd6);

    // Id counter wraps from 7 back to 0.
    push_cmd(1'b0, 4'd1, 4'd2);
    serve_job(1'b0, 1'b1, 3'd7);
    push_cmd(1'b0, 4'd8, 4'd8);
    serve_job(1'b0, 1'b1, 3'd0);

    // Reset mid-HCU with two jobs queued discards everything silently.
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 1'b0;
    bus.cmd_gridX = 4'd4;
    bus.cmd_gridY = 4'd4;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("t6_ready_%0d", k), 16'(bus.cmd_ready), 16'd1);
      tick();
    end
    bus.cmd_valid = 1'b0;
    wait_high("t6_lbp_start", 0, 4);
    tick();
    bus.lbp_done = 1'b1;
    tick();
    bus.lbp_done = 1'b0;
    check_val("t6_hcu_en", 16'(bus.hcu_enable), 16'd1);
    s0 = stat_cnt;
    l0 = lbp_cnt;
    #3;
    rst = 1'b1;
    #1;
    check_val("t6_async_hcu_en", 16'(bus.hcu_enable), 16'd0);
    check_val("t6_async_busy", 16'(bus.busy), 16'd0);
    check_val("t6_async_ready", 16'(bus.cmd_ready), 16'd1);
    check_val("t6_async_stat", 16'(bus.stat_valid), 16'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check_val("t6_no_stat", 16'(stat_cnt - s0), 16'd0);
    check_val("t6_no_lbp", 16'(lbp_cnt - l0), 16'd0);
    check_val("t6_busy_after", 16'(bus.busy), 16'd0);
    push_cmd(1'b0, 4'd2, 4'd4);
    serve_job(1'b0, 1'b1, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hist_job_sched.md
HIST_JOB_SCHED -- requirements
Module: hist_job_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command FIFO entries (power of two, 2..8).
REQ-002 Parameter TIMEOUT_CYC, default 16'd50000: per-stage watchdog limit in clk cycles.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  FIFO not full; transfer occurs when cmd_valid && cmd_ready.
REQ-007 cmd_mode  input  1  0 = train, 1 = predict.
REQ-008 cmd_gridX, cmd_gridY  input  4 each  grid divisions for the job.
REQ-009 lbp_start  output  1  one-cycle pulse that starts the LBP generator.
REQ-010 lbp_done  input  1  LBP image complete (pulse or level).
REQ-011 hcu_enable  output  1  level enable to the histogram unit.
REQ-012 hcu_mode  output  1  mode for the current job.
REQ-013 hcu_gridX, hcu_gridY  output  4 each  grid for the current job, stable while hcu_enable is high.
REQ-014 hcu_done  input  1  histogram unit finished.
REQ-015 match_start  output  1  one-cycle pulse that starts the matcher (predict jobs only).
REQ-016 match_done  input  1  matcher finished.
REQ-017 stat_valid  output  1  one-cycle job-completion pulse; no backpressure.
REQ-018 stat_id  output  3  job id of the reported job.
REQ-019 stat_code  output  2  00 ok, 01 bad grid, 10 timeout, 11 reserved (never driven).
REQ-020 busy  output  1  high whenever the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-021 Accepted commands SHALL be queued in FIFO order as {id, mode, gridX, gridY}; id is a 3-bit counter incremented per accept, wrapping 7 to 0.
REQ-022 cmd_ready SHALL be low when the FIFO is full; a simultaneous push and pop on a full FIFO SHALL NOT be allowed, because ready is based on registered occupancy.
REQ-023 FSM states SHALL be IDLE, CHECK, LBP_RUN, HCU_RUN, MATCH_RUN, REPORT.
REQ-024 IDLE -> CHECK when the FIFO is non-empty; the head is popped and latched into job registers in that transition cycle.
REQ-025 CHECK: if gridX or gridY is not in {1, 2, 4, 8}, go to REPORT with code 01 and issue no pulses; otherwise go to LBP_RUN and drive lbp_start high for exactly the first cycle of LBP_RUN.
REQ-026 LBP_RUN -> HCU_RUN on lbp_done; hcu_enable SHALL rise in the first HCU_RUN cycle and stay high until the cycle hcu_done is sampled high.
REQ-027 HCU_RUN on hcu_done: train -> REPORT (code 00); predict -> MATCH_RUN with match_start pulsed in its first cycle.
REQ-028 MATCH_RUN -> REPORT (code 00) on match_done.
REQ-029 Done inputs SHALL be ignored outside their own state; a done asserted in the same cycle as its start pulse SHALL NOT be honored.
REQ-030 Watchdog: a 16-bit counter cleared on entering each RUN state increments every cycle in that state; at TIMEOUT_CYC the FSM SHALL go to REPORT with code 10 and hcu_enable SHALL drop next cycle.
REQ-031 REPORT SHALL assert stat_valid for one cycle with the latched id and code, then return to IDLE; minimum back-to-back job spacing is one IDLE cycle.
REQ-032 hcu_mode, hcu_gridX and hcu_gridY SHALL hold the job registers and change only on the IDLE -> CHECK transition.

Reset
REQ-033 On rst, all of the following SHALL clear to 0 immediately: FSM (to IDLE), FIFO pointers and count, id counter, watchdog, and all outputs except cmd_ready.
REQ-034 cmd_ready SHALL read 1 after reset; reset mid-job SHALL discard the job and all queued jobs with no stat_valid.

Structure
REQ-035 The shared package SHALL hold the FSM state enum, the stat_code constants and the legal-grid constant set.
REQ-036 The FIFO SHALL be the single sub-module job_fifo, parameterized by depth and width; everything else stays in hist_job_sched.

Verification
REQ-037 Train job with grid 4x4: single push -> lbp_start pulse; lbp_done after 10 cycles -> hcu_enable high; hcu_done -> stat_valid with id 0, code 00, and no match_start.
REQ-038 Predict job with grid 8x8 -> sequence lbp, hcu, then match_start; match_done -> stat_valid with code 00.
REQ-039 Grid 3x4 -> no start pulses; stat_valid with code 01 two cycles after the pop.
REQ-040 Push 5 jobs back-to-back with no done responses -> cmd_ready low after 4 accepts while the first job is in progress; stat ids 0..4 reported in order once done inputs are supplied.
REQ-041 TIMEOUT_CYC=20 with hcu_done withheld -> stat_code 10 after 20 HCU_RUN cycles, hcu_enable low the following cycle, and the next job starts.
REQ-042 rst asserted during HCU_RUN with 2 jobs queued -> hcu_enable low asynchronously, busy low, no stat_valid; 9 accepted jobs -> id wraps 7 to 0.
